// File: rtl/request_front_end_if.sv
// Downstream scheduler port of the request front end: issued requests
// travel out, write acks and read data travel back.
interface request_front_end_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 30
);
  logic                  req_valid;
  logic                  req_type;
  logic [DATA_WIDTH-1:0] req_data;
  logic [ADDR_WIDTH-1:0] req_address;
  logic                  req_ready;
  logic                  wr_ack;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  // The front end is the master: it drives requests and receives completions.
  modport master (
    output req_valid, req_type, req_data, req_address,
    input  req_ready, wr_ack, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_type, req_data, req_address,
    output req_ready, wr_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/request_front_end.sv
// Host request front end: in-order request FIFO toward the scheduler, an
// outstanding-read limiter, and registered completion pulses back to the host.
module request_front_end #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 30,
  parameter int DEPTH      = 8,
  parameter int MAX_RD     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_request_type,
  input  logic [DATA_WIDTH-1:0] in_request_data,
  input  logic [ADDR_WIDTH-1:0] in_request_address,
  output logic                  out_busy,
  request_front_end_if.master   sched,
  output logic                  write_done,
  output logic                  read_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_RD + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [RW-1:0] RD_LIMIT   = RW'(MAX_RD);

  typedef struct packed {
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [RW-1:0]   rd_out;
  logic            fifo_nonempty;
  logic            rd_full;
  logic            push, pop, rd_pop;

  assign fifo_nonempty = (count != '0);
  assign rd_full       = (rd_out == RD_LIMIT);
  assign out_busy      = (count == COUNT_FULL) || rd_full;
  assign push          = in_valid && !out_busy;

  // Head fields read as zero while empty so stale/unwritten entries never leak.
  assign head = fifo_nonempty ? mem[rptr] : '0;

  // A read at the head waits for a free read slot and holds everything behind it.
  assign sched.req_valid   = fifo_nonempty && !(!head.is_write && rd_full);
  assign sched.req_type    = head.is_write;
  assign sched.req_data    = head.data;
  assign sched.req_address = head.addr;

  assign pop    = sched.req_valid && sched.req_ready;
  assign rd_pop = pop && !head.is_write;

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{is_write: in_request_type,
                             addr:     in_request_address,
                             data:     in_request_data};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      rd_out     <= '0;
      write_done <= 1'b0;
      read_done  <= 1'b0;
      data_out   <= '0;
      err        <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      case ({rd_pop, sched.rd_valid})
        2'b10:   rd_out <= rd_out + RW'(1);
        2'b01:   if (rd_out != '0) rd_out <= rd_out - RW'(1);
        default: ;
      endcase

      if (in_valid && out_busy) err[0] <= 1'b1;
      // Return with nothing outstanding is flagged but still forwarded below.
      if (sched.rd_valid && !rd_pop && rd_out == '0) err[1] <= 1'b1;

      write_done <= sched.wr_ack;
      read_done  <= sched.rd_valid;
      if (sched.rd_valid) data_out <= sched.rd_data;
    end
  end

endmodule
